// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the datapath.
// The sequencer (master) owns the control word; run/opcode come from the datapath/front panel.
interface sap_control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                pc_enable;
    logic                pc_out;
    logic                mar_load;
    logic                ram_oe;
    logic                ir_load;
    logic                ir_out;
    logic                a_load;
    logic                a_out;
    logic                b_load;
    logic                alu_out;
    logic                alu_sub;
    logic                out_load;
    logic                halted;
    logic [5:0]          t_state;

    modport master (
        input  run, opcode,
        output pc_enable, pc_out, mar_load, ram_oe, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load,
               halted, t_state
    );

    modport slave (
        output run, opcode,
        input  pc_enable, pc_out, mar_load, ram_oe, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load,
               halted, t_state
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// Six-phase fetch/execute sequencer for the SAP 8-bit CPU.
// Control word is a pure combinational decode of the registered phase and the IR opcode.
module sap_control_sequencer #(
    parameter int                  OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0] OP_LDA   = 4'h0,
    parameter logic [OPCODE_W-1:0] OP_ADD   = 4'h1,
    parameter logic [OPCODE_W-1:0] OP_SUB   = 4'h2,
    parameter logic [OPCODE_W-1:0] OP_OUT   = 4'he,
    parameter logic [OPCODE_W-1:0] OP_HLT   = 4'hf
) (
    input  logic                           clk,
    input  logic                           rst,
    sap_control_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    // Bit positions inside the packed control word.
    localparam int C_PCE  = 11;
    localparam int C_PCO  = 10;
    localparam int C_MAR  = 9;
    localparam int C_RAM  = 8;
    localparam int C_IRL  = 7;
    localparam int C_IRO  = 6;
    localparam int C_AL   = 5;
    localparam int C_AO   = 4;
    localparam int C_BL   = 3;
    localparam int C_ALU  = 2;
    localparam int C_SUB  = 1;
    localparam int C_OUTL = 0;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] w_ctl;
    logic [5:0]  w_t_state;
    logic        w_halted;
    logic        w_mem_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_mem_op = (bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
                      (bus.opcode == OP_SUB);

    always_comb begin
        w_state_next = r_state;
        w_ctl        = '0;
        w_t_state    = '0;
        w_halted     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) w_state_next = S_T1;
            end
            S_T1: begin
                w_t_state    = 6'b000001;
                w_ctl[C_PCO] = 1'b1;
                w_ctl[C_MAR] = 1'b1;
                w_state_next = S_T2;
            end
            S_T2: begin
                w_t_state    = 6'b000010;
                w_ctl[C_PCE] = 1'b1;
                w_state_next = S_T3;
            end
            S_T3: begin
                w_t_state    = 6'b000100;
                w_ctl[C_RAM] = 1'b1;
                w_ctl[C_IRL] = 1'b1;
                w_state_next = S_T4;
            end
            S_T4: begin
                w_t_state = 6'b001000;
                if (w_mem_op) begin
                    w_ctl[C_IRO] = 1'b1;
                    w_ctl[C_MAR] = 1'b1;
                end else if (bus.opcode == OP_OUT) begin
                    w_ctl[C_AO]   = 1'b1;
                    w_ctl[C_OUTL] = 1'b1;
                end
                w_state_next = (bus.opcode == OP_HLT) ? S_HALT : S_T5;
            end
            S_T5: begin
                w_t_state = 6'b010000;
                if (w_mem_op) begin
                    w_ctl[C_RAM] = 1'b1;
                    w_ctl[C_AL]  = (bus.opcode == OP_LDA);
                    w_ctl[C_BL]  = (bus.opcode != OP_LDA);
                end
                w_state_next = S_T6;
            end
            S_T6: begin
                w_t_state = 6'b100000;
                if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
                    w_ctl[C_ALU] = 1'b1;
                    w_ctl[C_AL]  = 1'b1;
                    w_ctl[C_SUB] = (bus.opcode == OP_SUB);
                end
                w_state_next = bus.run ? S_T1 : S_IDLE;
            end
            S_HALT: begin
                // Terminal until reset; run and opcode are deliberately ignored.
                w_halted = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign {bus.pc_enable, bus.pc_out, bus.mar_load, bus.ram_oe, bus.ir_load,
            bus.ir_out, bus.a_load, bus.a_out, bus.b_load, bus.alu_out,
            bus.alu_sub, bus.out_load} = w_ctl;
    assign bus.halted  = w_halted;
    assign bus.t_state = w_t_state;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: a directed vector table, hand sequences for reset/halt/pause,
// and random run/opcode traffic checked against a phase-counting reference model.
module tb_sap_control_sequencer;
    localparam logic [11:0] C_PCE  = 12'h800;
    localparam logic [11:0] C_PCO  = 12'h400;
    localparam logic [11:0] C_MAR  = 12'h200;
    localparam logic [11:0] C_RAM  = 12'h100;
    localparam logic [11:0] C_IRL  = 12'h080;
    localparam logic [11:0] C_IRO  = 12'h040;
    localparam logic [11:0] C_AL   = 12'h020;
    localparam logic [11:0] C_AO   = 12'h010;
    localparam logic [11:0] C_BL   = 12'h008;
    localparam logic [11:0] C_ALU  = 12'h004;
    localparam logic [11:0] C_SUB  = 12'h002;
    localparam logic [11:0] C_OUTL = 12'h001;

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic [11:0] ctl;
        logic        halted;
        logic [5:0]  t;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   m_phase = 0;   // 0 idle, 1..6 = T1..T6, 7 halted

    sap_control_sequencer_if #(.OPCODE_W(4)) bus ();

    sap_control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] actual_word();
        return {bus.pc_enable, bus.pc_out, bus.mar_load, bus.ram_oe, bus.ir_load,
                bus.ir_out, bus.a_load, bus.a_out, bus.b_load, bus.alu_out,
                bus.alu_sub, bus.out_load, bus.halted, bus.t_state};
    endfunction

    function automatic logic [18:0] model_word(input int ph, input logic [3:0] op);
        logic [11:0] c;
        logic [5:0]  t;
        logic        h;
        c = '0; t = '0; h = 1'b0;
        if (ph == 7) h = 1'b1;
        else if (ph >= 1) t = 6'(1 << (ph - 1));
        case (ph)
            1: c = C_PCO | C_MAR;
            2: c = C_PCE;
            3: c = C_RAM | C_IRL;
            4: if (op <= 4'h2) c = C_IRO | C_MAR; else if (op == 4'he) c = C_AO | C_OUTL;
            5: if (op == 4'h0) c = C_RAM | C_AL; else if (op == 4'h1 || op == 4'h2) c = C_RAM | C_BL;
            6: if (op == 4'h1) c = C_ALU | C_AL; else if (op == 4'h2) c = C_ALU | C_AL | C_SUB;
            default: c = '0;
        endcase
        return {c, h, t};
    endfunction

    function automatic int model_next(input int ph, input logic r, input logic [3:0] op);
        if (ph == 0) return r ? 1 : 0;
        if (ph == 7) return 7;
        if (ph == 4 && op == 4'hf) return 7;
        if (ph == 6) return r ? 1 : 0;
        return ph + 1;
    endfunction

    task automatic compare(input string name, input logic [18:0] exp);
        logic [18:0] act;
        act = actual_word();
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ctl=%03h halted=%b t=%06b, want ctl=%03h halted=%b t=%06b",
                     name, act[18:7], act[6], act[5:0], exp[18:7], exp[6], exp[5:0]);
        end
        vectors++;
        if ($countones({bus.pc_out, bus.ram_oe, bus.ir_out, bus.a_out, bus.alu_out}) > 1) begin
            errors++;
            $display("FAIL %s bus_drivers: got %b, want at most one set", name,
                     {bus.pc_out, bus.ram_oe, bus.ir_out, bus.a_out, bus.alu_out});
        end
    endtask

    // Apply run/opcode, take one clock edge, then check at the falling edge.
    task automatic step(input string name, input logic r, input logic [3:0] op);
        bus.run    = r;
        bus.opcode = op;
        @(posedge clk);
        m_phase = model_next(m_phase, r, op);
        @(negedge clk);
        compare($sformatf("%s ph%0d op%h", name, m_phase, op), model_word(m_phase, op));
        $display("step %-8s run=%b op=%h phase=%0d", name, r, op, m_phase);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        m_phase = 0;
        compare("reset", model_word(0, bus.opcode));
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] op, input logic [11:0] c,
                       input logic h, input logic [5:0] t);
        vec_t v;
        v.run = r; v.op = op; v.ctl = c; v.halted = h; v.t = t;
        tbl.push_back(v);
    endtask

    initial begin
        bus.run    = 1'b0;
        bus.opcode = 4'h0;

        // LDA, SUB, ADD, OUT, HLT back to back.
        add(1, 4'h0, C_PCO | C_MAR, 0, 6'b000001);
        add(1, 4'h0, C_PCE,         0, 6'b000010);
        add(1, 4'h0, C_RAM | C_IRL, 0, 6'b000100);
        add(1, 4'h0, C_IRO | C_MAR, 0, 6'b001000);
        add(1, 4'h0, C_RAM | C_AL,  0, 6'b010000);
        add(1, 4'h0, 12'h000,       0, 6'b100000);
        add(1, 4'h2, C_PCO | C_MAR, 0, 6'b000001);
        add(1, 4'h2, C_PCE,         0, 6'b000010);
        add(1, 4'h2, C_RAM | C_IRL, 0, 6'b000100);
        add(1, 4'h2, C_IRO | C_MAR, 0, 6'b001000);
        add(1, 4'h2, C_RAM | C_BL,  0, 6'b010000);
        add(1, 4'h2, C_ALU | C_AL | C_SUB, 0, 6'b100000);
        add(1, 4'h1, C_PCO | C_MAR, 0, 6'b000001);
        add(1, 4'h1, C_PCE,         0, 6'b000010);
        add(1, 4'h1, C_RAM | C_IRL, 0, 6'b000100);
        add(1, 4'h1, C_IRO | C_MAR, 0, 6'b001000);
        add(1, 4'h1, C_RAM | C_BL,  0, 6'b010000);
        add(1, 4'h1, C_ALU | C_AL,  0, 6'b100000);
        add(1, 4'he, C_PCO | C_MAR, 0, 6'b000001);
        add(1, 4'he, C_PCE,         0, 6'b000010);
        add(1, 4'he, C_RAM | C_IRL, 0, 6'b000100);
        add(1, 4'he, C_AO | C_OUTL, 0, 6'b001000);
        add(1, 4'he, 12'h000,       0, 6'b010000);
        add(1, 4'he, 12'h000,       0, 6'b100000);
        add(1, 4'hf, C_PCO | C_MAR, 0, 6'b000001);
        add(1, 4'hf, C_PCE,         0, 6'b000010);
        add(1, 4'hf, C_RAM | C_IRL, 0, 6'b000100);
        add(1, 4'hf, 12'h000,       0, 6'b001000);
        add(1, 4'hf, 12'h000,       1, 6'b000000);

        #12;
        do_reset();
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 4'(i * 3));

        for (int i = 0; i < tbl.size(); i++) begin
            bus.run    = tbl[i].run;
            bus.opcode = tbl[i].op;
            @(posedge clk);
            m_phase = model_next(m_phase, tbl[i].run, tbl[i].op);
            @(negedge clk);
            compare($sformatf("table[%0d]", i), {tbl[i].ctl, tbl[i].halted, tbl[i].t});
            $display("vec %0d run=%b op=%h", i, tbl[i].run, tbl[i].op);
        end

        // Halt holds for 20 cycles regardless of run/opcode.
        for (int i = 0; i < 20; i++) step("halt", 1'($urandom_range(0, 1)), 4'($urandom));
        do_reset();

        // Asynchronous reset in T3, checked before the next clock edge.
        step("pre", 1'b1, 4'h1);
        step("pre", 1'b1, 4'h1);
        step("pre", 1'b1, 4'h1);
        #1 rst = 1'b0;
        #1 m_phase = 0;
        compare("async_rst_T3", model_word(0, bus.opcode));
        @(negedge clk);
        rst = 1'b1;

        // Pause: run drops during T3, instruction completes then idles.
        step("pause", 1'b1, 4'h0);
        step("pause", 1'b1, 4'h5);
        step("pause", 1'b1, 4'h9);
        for (int i = 0; i < 4; i++) step("pause", 1'b0, 4'h0);
        step("pause", 1'b0, 4'h0);
        step("resume", 1'b1, 4'h7);
        for (int i = 0; i < 6; i++) step("nop", 1'b1, 4'h7);

        // Random traffic; an occasional reset pulls the DUT out of HALT.
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 7 && $urandom_range(0, 3) == 0) do_reset();
            step("rand", ($urandom_range(0, 7) != 0), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
